// File: rtl/control_unit.sv
// ============================================================================
// Module   : control_unit
// Purpose  : Multi-cycle FSM sequencing fetch/decode/execute for a small
//            16-bit processor datapath (LOAD, STORE, ADD, SUB, NOOP, HALT).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_unit #(
  parameter logic [2:0] ALU_PASS = 3'd0,
  parameter logic [2:0] ALU_ADD  = 3'd1,
  parameter logic [2:0] ALU_SUB  = 3'd2
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [15:0] IM_data,
  output logic        PC_clr,
  output logic        PC_up,
  output logic        IR_ld,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_addr,
  output logic        RF_W_en,
  output logic [3:0]  RF_Ra_addr,
  output logic [3:0]  RF_Rb_addr,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  OutState
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] c_OP_NOOP  = 4'd0;
  localparam logic [3:0] c_OP_LOAD  = 4'd1;
  localparam logic [3:0] c_OP_STORE = 4'd2;
  localparam logic [3:0] c_OP_ADD   = 4'd3;
  localparam logic [3:0] c_OP_SUB   = 4'd4;
  localparam logic [3:0] c_OP_HALT  = 4'd5;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_ir;
  logic [15:0] w_ir_nxt;

  logic        r_pc_clr;
  logic        r_pc_up;
  logic        r_ir_ld;
  logic [7:0]  r_d_addr;
  logic        r_d_wr;
  logic        r_rf_s;
  logic [3:0]  r_rf_w_addr;
  logic        r_rf_w_en;
  logic [3:0]  r_rf_ra_addr;
  logic [3:0]  r_rf_rb_addr;
  logic [2:0]  r_alu_s0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:   w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_DECODE;
      S_DECODE: begin
        case (r_ir[15:12])
          c_OP_NOOP:  w_state_nxt = S_NOOP;
          c_OP_LOAD:  w_state_nxt = S_LOAD_A;
          c_OP_STORE: w_state_nxt = S_STORE;
          c_OP_ADD:   w_state_nxt = S_ADD;
          c_OP_SUB:   w_state_nxt = S_SUB;
          c_OP_HALT:  w_state_nxt = S_HALT;
          default:    w_state_nxt = S_NOOP;
        endcase
      end
      S_NOOP:   w_state_nxt = S_FETCH;
      S_LOAD_A: w_state_nxt = S_LOAD_B;
      S_LOAD_B: w_state_nxt = S_FETCH;
      S_STORE:  w_state_nxt = S_FETCH;
      S_ADD:    w_state_nxt = S_FETCH;
      S_SUB:    w_state_nxt = S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_INIT;
    endcase
  end

  assign w_ir_nxt = (r_state == S_FETCH) ? IM_data : r_ir;

  // Outputs are registered against the next state so they line up with
  // r_state. Every state that drives IR fields is entered from DECODE or
  // LOAD_A, where r_ir already holds the settled instruction.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_state      <= S_INIT;
      r_ir         <= 16'h0000;
      r_pc_clr     <= 1'b1;
      r_pc_up      <= 1'b0;
      r_ir_ld      <= 1'b0;
      r_d_addr     <= 8'h00;
      r_d_wr       <= 1'b0;
      r_rf_s       <= 1'b0;
      r_rf_w_addr  <= 4'h0;
      r_rf_w_en    <= 1'b0;
      r_rf_ra_addr <= 4'h0;
      r_rf_rb_addr <= 4'h0;
      r_alu_s0     <= ALU_PASS;
    end else begin
      r_state      <= w_state_nxt;
      r_ir         <= w_ir_nxt;
      r_pc_clr     <= 1'b0;
      r_pc_up      <= 1'b0;
      r_ir_ld      <= 1'b0;
      r_d_addr     <= 8'h00;
      r_d_wr       <= 1'b0;
      r_rf_s       <= 1'b0;
      r_rf_w_addr  <= 4'h0;
      r_rf_w_en    <= 1'b0;
      r_rf_ra_addr <= 4'h0;
      r_rf_rb_addr <= 4'h0;
      r_alu_s0     <= ALU_PASS;
      case (w_state_nxt)
        S_INIT: r_pc_clr <= 1'b1;
        S_FETCH: begin
          r_ir_ld <= 1'b1;
          r_pc_up <= 1'b1;
        end
        S_LOAD_A: begin
          r_d_addr    <= r_ir[11:4];
          r_rf_s      <= 1'b1;
          r_rf_w_addr <= r_ir[3:0];
        end
        S_LOAD_B: begin
          r_d_addr    <= r_ir[11:4];
          r_rf_s      <= 1'b1;
          r_rf_w_addr <= r_ir[3:0];
          r_rf_w_en   <= 1'b1;
        end
        S_STORE: begin
          r_d_addr     <= r_ir[7:0];
          r_rf_ra_addr <= r_ir[11:8];
          r_d_wr       <= 1'b1;
        end
        S_ADD: begin
          r_rf_ra_addr <= r_ir[11:8];
          r_rf_rb_addr <= r_ir[7:4];
          r_rf_w_addr  <= r_ir[3:0];
          r_rf_w_en    <= 1'b1;
          r_alu_s0     <= ALU_ADD;
        end
        S_SUB: begin
          r_rf_ra_addr <= r_ir[11:8];
          r_rf_rb_addr <= r_ir[7:4];
          r_rf_w_addr  <= r_ir[3:0];
          r_rf_w_en    <= 1'b1;
          r_alu_s0     <= ALU_SUB;
        end
        default: ;
      endcase
    end
  end

  assign PC_clr     = r_pc_clr;
  assign PC_up      = r_pc_up;
  assign IR_ld      = r_ir_ld;
  assign D_addr     = r_d_addr;
  assign D_wr       = r_d_wr;
  assign RF_s       = r_rf_s;
  assign RF_W_addr  = r_rf_w_addr;
  assign RF_W_en    = r_rf_w_en;
  assign RF_Ra_addr = r_rf_ra_addr;
  assign RF_Rb_addr = r_rf_rb_addr;
  assign ALU_s0     = r_alu_s0;
  assign OutState   = r_state;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Self-checking bench for control_unit: instruction-level trace
//            model plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_unit;

  logic        clk;
  logic        Clr;
  logic [15:0] IM_data;
  logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState;
  logic [2:0]  ALU_s0;

  control_unit dut (
    .Clk        (clk),
    .Clr        (Clr),
    .IM_data    (IM_data),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IR_ld      (IR_ld),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .OutState   (OutState)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp_v);
    end
  endtask

  // Program memory and a simple program counter obeying PC_clr / PC_up
  logic [15:0] prog [0:15];
  logic [3:0]  pc;
  initial begin
    for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
    prog[0] = 16'h1A53;  // LOAD  R3 <- M[A5]
    prog[1] = 16'h3127;  // ADD   R7 <- R1 + R2
    prog[2] = 16'h4127;  // SUB   R7 <- R1 - R2
    prog[3] = 16'h2B3C;  // STORE M[3C] <- RB
    prog[4] = 16'hF000;  // unknown opcode -> NOOP
    prog[5] = 16'h0000;  // NOOP
    prog[6] = 16'h5000;  // HALT
  end
  initial pc = 4'd0;
  always @(posedge clk) begin
    if (PC_clr)     pc <= 4'd0;
    else if (PC_up) pc <= pc + 4'd1;
  end
  assign IM_data = prog[pc];

  // Expected per-cycle output vector
  typedef struct packed {
    logic [3:0] st;
    logic       pc_clr, pc_up, ir_ld;
    logic [7:0] d_addr;
    logic       d_wr, rf_s;
    logic [3:0] w_addr;
    logic       w_en;
    logic [3:0] ra, rb;
    logic [2:0] alu;
  } rec_t;

  function automatic rec_t blank(input logic [3:0] st);
    rec_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  rec_t q[$];
  int   model_pc = 0;
  bit   model_halted = 0;
  bit   clr_seen = 0;
  bit   valid = 0;

  // Expand one instruction into the cycle-by-cycle trace it must produce
  task automatic expand();
    rec_t r;
    logic [15:0] ins;
    if (model_halted) begin
      q.push_back(blank(4'd9));
      return;
    end
    ins = prog[model_pc[3:0]];
    model_pc++;
    r = blank(4'd1); r.ir_ld = 1; r.pc_up = 1; q.push_back(r);
    q.push_back(blank(4'd2));
    case (ins[15:12])
      4'd1: begin
        r = blank(4'd4); r.d_addr = ins[11:4]; r.rf_s = 1; r.w_addr = ins[3:0];
        q.push_back(r);
        r.st = 4'd5; r.w_en = 1; q.push_back(r);
      end
      4'd2: begin
        r = blank(4'd6); r.d_addr = ins[7:0]; r.ra = ins[11:8]; r.d_wr = 1;
        q.push_back(r);
      end
      4'd3, 4'd4: begin
        r = blank(ins[15:12] == 4'd3 ? 4'd7 : 4'd8);
        r.ra = ins[11:8]; r.rb = ins[7:4]; r.w_addr = ins[3:0]; r.w_en = 1;
        r.alu = (ins[15:12] == 4'd3) ? 3'd1 : 3'd2;
        q.push_back(r);
      end
      4'd5: begin
        model_halted = 1;
        q.push_back(blank(4'd9));
      end
      default: q.push_back(blank(4'd3));
    endcase
  endtask

  always @(posedge clk) clr_seen <= Clr;

  always @(negedge clk) begin
    rec_t e, a;
    bit do_cmp;
    do_cmp = 0;
    if (clr_seen) begin
      q.delete();
      model_pc = 0;
      model_halted = 0;
      valid = 1;
      e = blank(4'd0); e.pc_clr = 1;
      do_cmp = 1;
    end else if (valid) begin
      if (q.size() == 0) expand();
      e = q.pop_front();
      do_cmp = 1;
    end
    if (do_cmp) begin
      a = {OutState, PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr,
           RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL trace @%0t: got 0x%09h (state %0d), want 0x%09h (state %0d)",
                 $time, a, a.st, e, e.st);
      end
    end
  end

  int cyc;
  task automatic step_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic release_clr();
    @(posedge clk); #1;
    Clr = 1'b0;
    cyc = -1;
  endtask

  initial begin
    Clr = 1'b1;
    cyc = -100;
    @(posedge clk);
    release_clr();   // Clr held across two posedges

    step_to(0);
    check("init_state", OutState, 4'd0);
    check("init_pc_clr", PC_clr, 1'b1);
    check("init_alu", ALU_s0, 3'd0);
    step_to(1);
    check("fetch_state", OutState, 4'd1);
    check("fetch_ir_ld_pc_up", {IR_ld, PC_up}, 2'b11);
    step_to(2);
    check("decode_state", OutState, 4'd2);
    step_to(3);
    check("loada_state", OutState, 4'd4);
    check("loada_fields", {D_addr, RF_W_addr, RF_s, RF_W_en}, {8'hA5, 4'd3, 1'b1, 1'b0});
    step_to(4);
    check("loadb_state", OutState, 4'd5);
    check("loadb_wen", RF_W_en, 1'b1);
    step_to(5);
    check("after_load_fetch", OutState, 4'd1);
    step_to(7);
    check("add_fields", {OutState, RF_Ra_addr, RF_Rb_addr, RF_W_addr, RF_W_en, ALU_s0},
          {4'd7, 4'd1, 4'd2, 4'd7, 1'b1, 3'd1});
    step_to(10);
    check("sub_fields", {OutState, ALU_s0}, {4'd8, 3'd2});
    step_to(13);
    check("store_fields", {OutState, D_addr, RF_Ra_addr, D_wr}, {4'd6, 8'h3C, 4'hB, 1'b1});
    step_to(14);
    check("store_one_cycle", D_wr, 1'b0);
    step_to(16);
    check("noop_state", OutState, 4'd3);
    check("noop_enables", {D_wr, RF_W_en, PC_up, IR_ld}, 4'b0000);
    step_to(22);
    check("halt_state", OutState, 4'd9);
    step_to(35);
    check("halt_hold", {OutState, PC_up}, {4'd9, 1'b0});

    // Reset out of HALT
    Clr = 1'b1;
    @(negedge clk); #1;
    check("halt_clr_init", {OutState, PC_clr}, {4'd0, 1'b1});
    release_clr();
    step_to(3);
    check("loada_again", OutState, 4'd4);

    // Reset in the middle of a LOAD
    Clr = 1'b1;
    @(negedge clk); #1;
    check("midload_init", {OutState, RF_W_en}, {4'd0, 1'b0});
    release_clr();
    step_to(0);
    check("midload_release_init", {OutState, PC_clr}, {4'd0, 1'b1});
    step_to(4);
    check("loadb_after_recover", {OutState, RF_W_en}, {4'd5, 1'b1});
    step_to(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
